// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the load/store unit: access sizes, FSM states and
// the access-legality rule used by both the FSM and the reference of lanes.
package mem_lsu_pkg;

    localparam logic [1:0] SZ_BYTE    = 2'b00;
    localparam logic [1:0] SZ_HALF    = 2'b01;
    localparam logic [1:0] SZ_WORD    = 2'b10;
    localparam logic [1:0] SZ_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        LOAD_WAIT = 2'b01,
        RESP      = 2'b10
    } lsu_state_e;

    // A request is rejected when its size is illegal or its offset is not
    // naturally aligned for that size.
    function automatic logic access_err(input logic [1:0] size, input logic [1:0] off);
        logic err;
        case (size)
            SZ_BYTE: err = 1'b0;
            SZ_HALF: err = off[0];
            SZ_WORD: err = (off != 2'b00);
            default: err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// Byte-lane steering for the LSU: store byte enables and data replication,
// and load lane extraction with sign or zero extension.
module mem_lsu_align
    import mem_lsu_pkg::*;
(
    input  logic [1:0]  st_size_i,
    input  logic [1:0]  st_off_i,
    input  logic [31:0] st_wdata_i,
    output logic [3:0]  st_be_o,
    output logic [31:0] st_din_o,
    input  logic [1:0]  ld_size_i,
    input  logic [1:0]  ld_off_i,
    input  logic        ld_unsigned_i,
    input  logic [31:0] ld_raw_i,
    output logic [31:0] ld_data_o
);

    logic [7:0]  ld_byte_s;
    logic [15:0] ld_half_s;
    logic        ld_sign_s;

    // Store side: lanes selected by size and offset, data replicated to all lanes.
    always_comb begin
        st_be_o  = 4'b0000;
        st_din_o = st_wdata_i;
        case (st_size_i)
            SZ_BYTE: begin
                st_be_o  = 4'b0001 << st_off_i;
                st_din_o = {4{st_wdata_i[7:0]}};
            end
            SZ_HALF: begin
                st_be_o  = st_off_i[1] ? 4'b1100 : 4'b0011;
                st_din_o = {2{st_wdata_i[15:0]}};
            end
            SZ_WORD: begin
                st_be_o  = 4'b1111;
                st_din_o = st_wdata_i;
            end
            default: begin
                st_be_o  = 4'b0000;
                st_din_o = st_wdata_i;
            end
        endcase
    end

    // Load side: pick the addressed lane, then extend to the full word.
    always_comb begin
        case (ld_off_i)
            2'b00:   ld_byte_s = ld_raw_i[7:0];
            2'b01:   ld_byte_s = ld_raw_i[15:8];
            2'b10:   ld_byte_s = ld_raw_i[23:16];
            default: ld_byte_s = ld_raw_i[31:24];
        endcase
        ld_half_s = ld_off_i[1] ? ld_raw_i[31:16] : ld_raw_i[15:0];
        ld_sign_s = 1'b0;
        case (ld_size_i)
            SZ_BYTE: begin
                ld_sign_s = ~ld_unsigned_i & ld_byte_s[7];
                ld_data_o = {{24{ld_sign_s}}, ld_byte_s};
            end
            SZ_HALF: begin
                ld_sign_s = ~ld_unsigned_i & ld_half_s[15];
                ld_data_o = {{16{ld_sign_s}}, ld_half_s};
            end
            default: begin
                ld_data_o = ld_raw_i;
            end
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// Load/store initiator for a byte-enabled word RAM with 1-cycle read latency.
// Holds the request FSM and the registered response; lane logic is in mem_lsu_align.
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [ADDR_WIDTH+1:0] req_addr_i,
    input  logic [1:0]            req_size_i,
    input  logic                  req_unsigned_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    output logic                  rsp_valid_o,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_din_o,
    output logic                  mem_we_o,
    output logic                  mem_be0_o,
    output logic                  mem_be1_o,
    output logic                  mem_be2_o,
    output logic                  mem_be3_o,
    input  logic [DATA_WIDTH-1:0] mem_dout_i
);

    if (DATA_WIDTH != 32) begin : g_bad_data_width
        $error("mem_lsu: DATA_WIDTH must be 32");
    end

    lsu_state_e  state_q, state_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_err_q, rsp_err_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic [1:0]  ld_off_q, ld_off_d;
    logic [1:0]  ld_size_q, ld_size_d;
    logic        ld_unsigned_q, ld_unsigned_d;

    logic        accept_s;
    logic        req_err_s;
    logic [3:0]  st_be_s;
    logic [31:0] st_din_s;
    logic [31:0] ld_data_s;

    assign req_err_s = access_err(req_size_i, req_addr_i[1:0]);

    mem_lsu_align u_align (
        .st_size_i     (req_size_i),
        .st_off_i      (req_addr_i[1:0]),
        .st_wdata_i    (req_wdata_i),
        .st_be_o       (st_be_s),
        .st_din_o      (st_din_s),
        .ld_size_i     (ld_size_q),
        .ld_off_i      (ld_off_q),
        .ld_unsigned_i (ld_unsigned_q),
        .ld_raw_i      (mem_dout_i),
        .ld_data_o     (ld_data_s)
    );

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: stores and errors answer directly, loads wait one RAM cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    state_d = (req_we_i || req_err_s) ? RESP : LOAD_WAIT;
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD_WAIT: state_d = RESP;
            RESP:      state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Outputs: RAM controls are combinational from the accepted request;
    // ready is held low while reset is asserted.
    always_comb begin
        req_ready_o   = rst_ni && (state_q == IDLE);
        accept_s      = req_valid_i && req_ready_o;
        mem_addr_o    = req_addr_i[ADDR_WIDTH+1:2];
        mem_din_o     = st_din_s;
        mem_we_o      = accept_s && req_we_i && !req_err_s;
        {mem_be3_o, mem_be2_o, mem_be1_o, mem_be0_o} =
            (accept_s && !req_err_s) ? st_be_s : 4'b0000;

        rsp_valid_d   = (state_d == RESP);
        rsp_err_d     = 1'b0;
        rsp_rdata_d   = rsp_rdata_q;
        ld_off_d      = ld_off_q;
        ld_size_d     = ld_size_q;
        ld_unsigned_d = ld_unsigned_q;
        case (state_q)
            IDLE: begin
                if (accept_s && (req_we_i || req_err_s)) begin
                    rsp_err_d   = req_err_s;
                    rsp_rdata_d = 32'd0;
                end else if (accept_s) begin
                    ld_off_d      = req_addr_i[1:0];
                    ld_size_d     = req_size_i;
                    ld_unsigned_d = req_unsigned_i;
                end else begin
                    rsp_rdata_d = rsp_rdata_q;
                end
            end
            LOAD_WAIT: rsp_rdata_d = ld_data_s;
            default:   rsp_rdata_d = rsp_rdata_q;
        endcase

        rsp_valid_o = rsp_valid_q;
        rsp_err_o   = rsp_err_q;
        rsp_rdata_o = rsp_rdata_q;
    end

    // Response and latched load-request registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_valid_q   <= 1'b0;
            rsp_err_q     <= 1'b0;
            rsp_rdata_q   <= 32'd0;
            ld_off_q      <= 2'b00;
            ld_size_q     <= SZ_BYTE;
            ld_unsigned_q <= 1'b0;
        end else begin
            rsp_valid_q   <= rsp_valid_d;
            rsp_err_q     <= rsp_err_d;
            rsp_rdata_q   <= rsp_rdata_d;
            ld_off_q      <= ld_off_d;
            ld_size_q     <= ld_size_d;
            ld_unsigned_q <= ld_unsigned_d;
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu: directed vector table, reset-during-load sequence and
// random traffic checked against a byte-array model of memory.
module tb_mem_lsu;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        req_valid_i, req_ready_o, req_we_i, req_unsigned_i;
    logic [13:0] req_addr_i;
    logic [1:0]  req_size_i;
    logic [31:0] req_wdata_i;
    logic        rsp_valid_o, rsp_err_o;
    logic [31:0] rsp_rdata_o;
    logic [11:0] mem_addr_o;
    logic [31:0] mem_din_o, mem_dout_i;
    logic        mem_we_o, mem_be0_o, mem_be1_o, mem_be2_o, mem_be3_o;

    int total = 0;
    int bad   = 0;

    bit [31:0] ram [4096];
    bit [7:0]  ref_mem [256];

    typedef struct {
        logic        we;
        logic [13:0] addr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] din;
        logic        mwe;
        logic        err;
        logic [31:0] rdata;
        int          lat;
    } vec_t;

    vec_t vecs [14];

    mem_lsu dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
        .req_addr_i(req_addr_i), .req_size_i(req_size_i), .req_unsigned_i(req_unsigned_i),
        .req_wdata_i(req_wdata_i), .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o),
        .rsp_err_o(rsp_err_o), .mem_addr_o(mem_addr_o), .mem_din_o(mem_din_o),
        .mem_we_o(mem_we_o), .mem_be0_o(mem_be0_o), .mem_be1_o(mem_be1_o),
        .mem_be2_o(mem_be2_o), .mem_be3_o(mem_be3_o), .mem_dout_i(mem_dout_i)
    );

    always #5 clk_i = ~clk_i;

    // Byte-enabled RAM with 1-cycle synchronous read.
    always @(posedge clk_i) begin
        if (mem_we_o) begin
            if (mem_be0_o) ram[mem_addr_o][7:0]   <= mem_din_o[7:0];
            if (mem_be1_o) ram[mem_addr_o][15:8]  <= mem_din_o[15:8];
            if (mem_be2_o) ram[mem_addr_o][23:16] <= mem_din_o[23:16];
            if (mem_be3_o) ram[mem_addr_o][31:24] <= mem_din_o[31:24];
        end
        mem_dout_i <= ram[mem_addr_o];
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    function automatic logic model_err(input logic [1:0] size, input int addr);
        return (size == 2'd3) || (size == 2'd1 && addr % 2 != 0) || (size == 2'd2 && addr % 4 != 0);
    endfunction

    function automatic logic [31:0] model_load(input int addr, input logic [1:0] size, input logic uns);
        int n;
        logic [31:0] v;
        n = 1 << size;
        v = 32'd0;
        for (int i = 0; i < n; i++) v = v | (32'(ref_mem[addr + i]) << (8 * i));
        if (!uns && n < 4 && v[8 * n - 1]) v = v | (32'hFFFF_FFFF << (8 * n));
        return v;
    endfunction

    // Issues one request from IDLE and returns what was seen; ends one cycle after the response.
    task automatic do_req(input logic we, input logic [13:0] addr, input logic [1:0] size,
                          input logic uns, input logic [31:0] wd,
                          output logic [31:0] rdata, output logic err, output int lat,
                          output logic [3:0] be, output logic [31:0] din,
                          output logic mwe, output logic [11:0] maddr);
        logic got;
        req_valid_i = 1'b1; req_we_i = we; req_addr_i = addr;
        req_size_i = size; req_unsigned_i = uns; req_wdata_i = wd;
        #1;
        check("ready_idle", 32'(req_ready_o), 32'd1);
        be    = {mem_be3_o, mem_be2_o, mem_be1_o, mem_be0_o};
        din   = mem_din_o;
        mwe   = mem_we_o;
        maddr = mem_addr_o;
        @(posedge clk_i); #1;
        if (we && !model_err(size, int'(addr)))
            for (int i = 0; i < (1 << size); i++) ref_mem[int'(addr) + i] = wd[8 * i +: 8];
        req_we_i = 1'b1; req_addr_i = 14'($urandom); req_size_i = 2'($urandom);
        req_wdata_i = $urandom;
        lat = 0; rdata = 32'd0; err = 1'b0; got = 1'b0;
        while (lat < 8 && !got) begin
            @(negedge clk_i);
            lat++;
            check("busy_ready", 32'(req_ready_o), 32'd0);
            check("busy_we", 32'(mem_we_o), 32'd0);
            check("busy_be", 32'({mem_be3_o, mem_be2_o, mem_be1_o, mem_be0_o}), 32'd0);
            if (rsp_valid_o === 1'b1) begin
                rdata = rsp_rdata_o;
                err   = rsp_err_o;
                got   = 1'b1;
            end
        end
        req_valid_i = 1'b0;
        if (!got) check("rsp_timeout", 32'd0, 32'd1);
        @(posedge clk_i); #1;
        check("pulse_width", 32'(rsp_valid_o), 32'd0);
    endtask

    initial begin
        logic [31:0] rd, din, wd;
        logic        er, mwe, we, uns, e_err;
        logic [3:0]  be;
        logic [11:0] maddr;
        logic [13:0] addr;
        logic [1:0]  size;
        logic [31:0] e_rd;
        int          lat;

        vecs[0]  = '{1'b1, 14'h010, 2'd2, 1'b0, 32'hDEADBEEF, 4'hF, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0, 1};
        vecs[1]  = '{1'b1, 14'h013, 2'd0, 1'b0, 32'h000000A5, 4'h8, 32'hA5A5A5A5, 1'b1, 1'b0, 32'h0, 1};
        vecs[2]  = '{1'b0, 14'h010, 2'd2, 1'b0, 32'h0, 4'hF, 32'h0, 1'b0, 1'b0, 32'hA5ADBEEF, 2};
        vecs[3]  = '{1'b0, 14'h013, 2'd0, 1'b0, 32'h0, 4'h8, 32'h0, 1'b0, 1'b0, 32'hFFFFFFA5, 2};
        vecs[4]  = '{1'b0, 14'h013, 2'd0, 1'b1, 32'h0, 4'h8, 32'h0, 1'b0, 1'b0, 32'h000000A5, 2};
        vecs[5]  = '{1'b1, 14'h012, 2'd1, 1'b0, 32'h00008001, 4'hC, 32'h80018001, 1'b1, 1'b0, 32'h0, 1};
        vecs[6]  = '{1'b0, 14'h012, 2'd1, 1'b0, 32'h0, 4'hC, 32'h0, 1'b0, 1'b0, 32'hFFFF8001, 2};
        vecs[7]  = '{1'b0, 14'h012, 2'd1, 1'b1, 32'h0, 4'hC, 32'h0, 1'b0, 1'b0, 32'h00008001, 2};
        vecs[8]  = '{1'b0, 14'h010, 2'd2, 1'b0, 32'h0, 4'hF, 32'h0, 1'b0, 1'b0, 32'h8001BEEF, 2};
        vecs[9]  = '{1'b1, 14'h011, 2'd2, 1'b0, 32'h12345678, 4'h0, 32'h0, 1'b0, 1'b1, 32'h0, 1};
        vecs[10] = '{1'b1, 14'h013, 2'd1, 1'b0, 32'h0000FFFF, 4'h0, 32'h0, 1'b0, 1'b1, 32'h0, 1};
        vecs[11] = '{1'b1, 14'h010, 2'd3, 1'b0, 32'hCAFEF00D, 4'h0, 32'h0, 1'b0, 1'b1, 32'h0, 1};
        vecs[12] = '{1'b0, 14'h014, 2'd3, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b1, 32'h0, 1};
        vecs[13] = '{1'b0, 14'h010, 2'd2, 1'b0, 32'h0, 4'hF, 32'h0, 1'b0, 1'b0, 32'h8001BEEF, 2};

        rst_ni = 1'b0;
        req_valid_i = 1'b1; req_we_i = 1'b1; req_addr_i = 14'h010;
        req_size_i = 2'd2; req_unsigned_i = 1'b0; req_wdata_i = 32'h11111111;
        #2;
        check("rst_ready", 32'(req_ready_o), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        check("rst_rsp_err", 32'(rsp_err_o), 32'd0);
        check("rst_rdata", rsp_rdata_o, 32'd0);
        check("rst_we", 32'(mem_we_o), 32'd0);
        check("rst_be", 32'({mem_be3_o, mem_be2_o, mem_be1_o, mem_be0_o}), 32'd0);
        req_valid_i = 1'b0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i) rst_ni = 1'b1;
        @(posedge clk_i); #1;

        for (int i = 0; i < 14; i++) begin
            do_req(vecs[i].we, vecs[i].addr, vecs[i].size, vecs[i].uns, vecs[i].wdata,
                   rd, er, lat, be, din, mwe, maddr);
            check($sformatf("v%0d_addr", i), 32'(maddr), 32'(vecs[i].addr[13:2]));
            check($sformatf("v%0d_we", i), 32'(mwe), 32'(vecs[i].mwe));
            if (!vecs[i].err) check($sformatf("v%0d_be", i), 32'(be), 32'(vecs[i].be));
            if (vecs[i].mwe) check($sformatf("v%0d_din", i), din, vecs[i].din);
            check($sformatf("v%0d_err", i), 32'(er), 32'(vecs[i].err));
            check($sformatf("v%0d_rdata", i), rd, vecs[i].rdata);
            check($sformatf("v%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
        end

        // Reset while a load is waiting for RAM data.
        req_valid_i = 1'b1; req_we_i = 1'b0; req_addr_i = 14'h010;
        req_size_i = 2'd2; req_unsigned_i = 1'b0;
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        rst_ni = 1'b0;
        #1;
        check("mid_rst_ready", 32'(req_ready_o), 32'd0);
        check("mid_rst_valid", 32'(rsp_valid_o), 32'd0);
        check("mid_rst_rdata", rsp_rdata_o, 32'd0);
        check("mid_rst_err", 32'(rsp_err_o), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            check("mid_rst_no_pulse", 32'(rsp_valid_o), 32'd0);
        end
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
        check("post_rst_valid", 32'(rsp_valid_o), 32'd0);
        wd = $urandom;
        do_req(1'b1, 14'h020, 2'd2, 1'b0, wd, rd, er, lat, be, din, mwe, maddr);
        check("b2b_st_lat", 32'(lat), 32'd1);
        check("b2b_st_we", 32'(mwe), 32'd1);
        do_req(1'b0, 14'h020, 2'd2, 1'b0, 32'd0, rd, er, lat, be, din, mwe, maddr);
        check("b2b_ld_lat", 32'(lat), 32'd2);
        check("b2b_ld_data", rd, wd);

        // Random traffic against the byte-array model.
        for (int n = 0; n < 150; n++) begin
            we    = 1'($urandom_range(0, 1));
            addr  = 14'($urandom_range(0, 63));
            size  = 2'($urandom_range(0, 3));
            uns   = 1'($urandom_range(0, 1));
            wd    = $urandom;
            e_err = model_err(size, int'(addr));
            e_rd  = (!we && !e_err) ? model_load(int'(addr), size, uns) : 32'd0;
            do_req(we, addr, size, uns, wd, rd, er, lat, be, din, mwe, maddr);
            check("rnd_err", 32'(er), 32'(e_err));
            check("rnd_rdata", rd, e_rd);
            check("rnd_lat", 32'(lat), (!we && !e_err) ? 32'd2 : 32'd1);
            check("rnd_we", 32'(mwe), 32'(we && !e_err));
            check("rnd_addr", 32'(maddr), 32'(addr[13:2]));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
Load/store initiator for the on-chip byte-enabled word RAM, with 1-cycle synchronous read. Accepts byte/half/word requests from the core with byte addresses. Generates the word address, byte enables and replicated store data. Extracts and sign- or zero-extends load data, and flags misaligned or illegal accesses without touching memory.

Parameters:
ADDR_WIDTH, 12, RAM word-address width; byte address is ADDR_WIDTH+2 bits
DATA_WIDTH, 32, RAM data width; only 32 is supported, and an elaboration-time check rejects other values

Ports:
clk_i  in  1  clock, all state on rising edge
rst_ni  in  1  asynchronous active-low reset
req_valid_i  in  1  request valid
req_ready_o  out  1  request accepted when valid&ready
req_we_i  in  1  1=store, 0=load
req_addr_i  in  ADDR_WIDTH+2  byte address
req_size_i  in  2  00=byte, 01=half, 10=word, 11=illegal
req_unsigned_i  in  1  zero-extend loads when 1
req_wdata_i  in  32  store data, right-aligned
rsp_valid_o  out  1  one-cycle response pulse
rsp_rdata_o  out  32  extended load data; 0 for stores and errors
rsp_err_o  out  1  misaligned/illegal, qualified by rsp_valid_o
mem_addr_o  out  ADDR_WIDTH  word address = req_addr_i[ADDR_WIDTH+1:2]
mem_din_o  out  32  replicated store data
mem_we_o  out  1  RAM write enable
mem_be0_o..mem_be3_o  out  1 each  byte-lane enables
mem_dout_i  in  32  RAM read data, valid the cycle after the address edge

Behaviour:
- Clock is clk_i; reset is asynchronous and active-low on rst_ni.
- Reset values: state IDLE, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, mem_we_o=0, all byte enables 0, req_ready_o=0 while rst_ni is low.
- States are IDLE, LOAD_WAIT and RESP.
- req_ready_o is 1 only in IDLE. The response is not back-pressured; the core must sink it.
- mem_* outputs are combinational from the request in IDLE, gated by req_valid_i. In other states, mem_we_o=0 and the byte enables are 0.
- Error rule: err = size==11, or (half & addr[0]), or (word & addr[1:0]!=0).
- IDLE, request accepted at edge N:
  - err: mem_we_o forced 0, go to RESP; cycle N+1 gives rsp_valid_o=1, rsp_err_o=1, rsp_rdata_o=0.
  - store: mem_we_o=1 during the accept cycle, so the RAM writes at edge N. Go to RESP; rsp_valid_o=1 in cycle N+1 with err=0.
  - load: address presented at edge N. Latch offset addr[1:0], size and unsigned, then go to LOAD_WAIT.
- LOAD_WAIT: mem_dout_i is valid. At edge N+1, register the extracted data into rsp_rdata_o and go to RESP. rsp_valid_o=1 in cycle N+2.
- RESP: rsp_valid_o high for exactly one cycle, then IDLE. The next request can be accepted in the cycle after RESP.
- Throughput: one store or error per 2 cycles; one load per 3 cycles.
- Byte enables:
  - byte: only lane addr[1:0]
  - half: 0011 if addr[1]==0, 1100 if addr[1]==1
  - word: 1111
- Store data:
  - byte: {4{wdata[7:0]}}
  - half: {2{wdata[15:0]}}
  - word: wdata
- Load extraction:
  - byte: lane addr[1:0]
  - half: upper or lower 16 bits by addr[1]
  - result bit 7 (byte) or bit 15 (half) is replicated upward unless unsigned
- Reset mid-operation returns to IDLE immediately with rsp_valid_o=0 and the pending response dropped. A write already clocked into the RAM stays committed.
- req_* inputs are ignored outside IDLE.

Decomposition:
- Shared package holds:
  - size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10
  - state encoding IDLE/LOAD_WAIT/RESP
  - function/constant for the error rule
- One combinational sub-module, mem_lsu_align, covers:
  - byte-enable generation
  - store-data replication
  - load extraction and extension
- mem_lsu keeps the FSM and the response registers.

Test Plan:
- Store word 0xDEADBEEF at byte addr 0x010 -> in the accept cycle mem_addr_o=0x004, be=1111, mem_we_o=1; next cycle rsp_valid_o=1, err=0, rdata=0.
- Store byte 0xA5 at 0x013 -> be=1000, mem_din_o=0xA5A5A5A5; then load word 0x010 -> rsp_rdata_o=0xA5ADBEEF, 2 cycles after accept.
- Load byte 0x013, signed -> 0xFFFFFFA5; unsigned -> 0x000000A5; req_ready_o low in LOAD_WAIT and RESP.
- Store half 0x8001 at 0x012, then load half signed 0x012 -> 0xFFFF8001; unsigned -> 0x00008001; word at 0x010 -> 0x8001BEEF.
- Store word at 0x011, half at 0x013, and size=11 -> mem_we_o never 1, rsp_err_o=1 with rsp_valid_o one cycle after accept; a reload of 0x010 is unchanged.
- Assert rst_ni low during LOAD_WAIT -> outputs go to reset values immediately and no rsp_valid_o pulse appears. After release, back-to-back store then load to 0x020 completes with correct data and 2/3-cycle timing.
